// File: rtl/rc_pkg.sv
// Shared constants, state encoding and report payload type for the RC report scheduler.
package rc_pkg;

  localparam int unsigned RC_CHANNELS = 7;
  localparam int unsigned RC_WIDTH    = 17;
  localparam int unsigned RC_SEL_W    = 3;
  localparam int unsigned RC_DATA_W   = 24;
  localparam int unsigned RC_CTRL_W   = 4;
  localparam int unsigned RC_CFG_W    = 24;
  localparam int unsigned RC_HOLD_W   = 8;

  localparam int unsigned CFG_EN_LSB  = 0;
  localparam int unsigned CFG_IVL_LSB = 8;
  localparam int unsigned CFG_CLR_OVR = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [RC_CTRL_W-1:0] ctrl;
    logic [RC_DATA_W-1:0] data;
  } report_t;

  // Next round-robin start point: one past the served channel, wrapping at CHANNELS.
  function automatic logic [RC_SEL_W-1:0] rr_next(input logic [RC_SEL_W-1:0] sel);
    return (32'(sel) == RC_CHANNELS - 1) ? '0 : sel + RC_SEL_W'(1);
  endfunction

endpackage

// File: rtl/rc_report_scheduler_if.sv
// Host report channel: scheduler drives the report, host answers with out_wr_rdy.
interface rc_report_scheduler_if;
  import rc_pkg::*;

  logic [RC_DATA_W-1:0] out_data;
  logic [RC_CTRL_W-1:0] out_ctrl;
  logic                 out_wr;
  logic                 out_wr_rdy;

  modport master (output out_data, output out_ctrl, output out_wr, input out_wr_rdy);
  modport slave  (input out_data, input out_ctrl, input out_wr, output out_wr_rdy);

endinterface

// File: rtl/rc_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo CHANNELS.
module rc_rr_picker
  import rc_pkg::*;
(
  input  logic [RC_CHANNELS-1:0] req_i,
  input  logic [RC_SEL_W-1:0]    ptr_i,
  output logic                   any_c,
  output logic [RC_SEL_W-1:0]    grant_c
);

  int unsigned idx;

  // Walk from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    any_c   = |req_i;
    grant_c = '0;
    idx     = 0;
    for (int unsigned k = RC_CHANNELS; k > 0; k--) begin
      idx = 32'(ptr_i) + k - 1;
      if (idx >= RC_CHANNELS) idx = idx - RC_CHANNELS;
      if (req_i[RC_SEL_W'(idx)]) grant_c = RC_SEL_W'(idx);
    end
  end

endmodule

// File: rtl/rc_report_scheduler.sv
// Shares the host report channel between the RC report sources using capture slots,
// round-robin selection, per-channel rate holdoff and sticky overrun flags.
module rc_report_scheduler
  import rc_pkg::*;
#(
  parameter int unsigned RATE_DIV = 50000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [RC_CFG_W-1:0]             cfg_data,
  input  logic                            cfg_wr,
  input  logic [RC_CHANNELS-1:0]          ch_stb,
  input  logic [RC_CHANNELS*RC_WIDTH-1:0] ch_data,
  rc_report_scheduler_if.master           host,
  output logic [RC_CHANNELS-1:0]          pending,
  output logic [RC_CHANNELS-1:0]          overrun,
  output logic                            busy
);

  localparam int unsigned     PRE_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RATE_DIV - 1);

  state_e                 state_q, state_d;
  report_t                rep_q, rep_d;
  logic                   out_wr_q, out_wr_d;
  logic                   busy_q;
  logic [RC_SEL_W-1:0]    ch_sel_q, ch_sel_d;
  logic [RC_SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [RC_CHANNELS-1:0] enable_q, enable_d;
  logic [RC_CHANNELS-1:0] pending_q, pending_d;
  logic [RC_CHANNELS-1:0] overrun_q, overrun_d;
  logic [RC_HOLD_W-1:0]   interval_q, interval_d;
  logic [RC_WIDTH-1:0]    slot_q [RC_CHANNELS];
  logic [RC_WIDTH-1:0]    slot_d [RC_CHANNELS];
  logic [RC_HOLD_W-1:0]   hold_q [RC_CHANNELS];
  logic [RC_HOLD_W-1:0]   hold_d [RC_CHANNELS];
  logic [PRE_W-1:0]       pre_q, pre_d;

  logic                   tick_c;
  logic                   accept_c;
  logic                   any_c;
  logic [RC_SEL_W-1:0]    grant_c;
  logic [RC_CHANNELS-1:0] cap_c;
  logic [RC_CHANNELS-1:0] elig_c;
  logic [RC_CHANNELS-1:0] new_en_c;
  logic [RC_WIDTH-1:0]    grant_data_c;
  logic                   unused_cfg;

  assign tick_c   = (pre_q == PRE_MAX);
  assign pre_d    = tick_c ? '0 : pre_q + PRE_W'(1);
  assign accept_c = (state_q == ST_SEND) & out_wr_q & host.out_wr_rdy;
  assign cap_c    = ch_stb & enable_q;
  assign new_en_c = cfg_data[CFG_EN_LSB +: RC_CHANNELS];

  assign unused_cfg = ^{cfg_data[RC_CFG_W-1:CFG_CLR_OVR+1], cfg_data[CFG_IVL_LSB-1:RC_CHANNELS]};

  // Configuration, capture slots, holdoff counters and eligibility.
  always_comb begin
    enable_d   = enable_q;
    interval_d = interval_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    elig_c     = '0;
    if (cfg_wr) begin
      enable_d   = new_en_c;
      interval_d = cfg_data[CFG_IVL_LSB +: RC_HOLD_W];
      if (cfg_data[CFG_CLR_OVR]) overrun_d = '0;
    end
    for (int unsigned i = 0; i < RC_CHANNELS; i++) begin
      if (accept_c && (ch_sel_q == RC_SEL_W'(i))) begin
        pending_d[i] = 1'b0;
        hold_d[i]    = interval_q;
      end else if (tick_c && (hold_q[i] != '0)) begin
        hold_d[i] = hold_q[i] - RC_HOLD_W'(1);
      end
      // A capture racing the accept of the same channel re-arms pending without an overrun.
      if (cap_c[i]) begin
        slot_d[i]    = ch_data[RC_WIDTH*i +: RC_WIDTH];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !(accept_c && (ch_sel_q == RC_SEL_W'(i)))) overrun_d[i] = 1'b1;
      end
      if (cfg_wr && !new_en_c[i]) pending_d[i] = 1'b0;
      elig_c[i] = pending_q[i] & enable_q[i] & (hold_q[i] == '0);
    end
  end

  rc_rr_picker u_picker (
    .req_i   (elig_c),
    .ptr_i   (rr_ptr_q),
    .any_c   (any_c),
    .grant_c (grant_c)
  );

  // Report FSM: latch the granted slot in IDLE, hold it in SEND until the host accepts.
  always_comb begin
    state_d      = state_q;
    rep_d        = rep_q;
    out_wr_d     = out_wr_q;
    ch_sel_d     = ch_sel_q;
    rr_ptr_d     = rr_ptr_q;
    grant_data_c = '0;
    for (int unsigned i = 0; i < RC_CHANNELS; i++) begin
      if (grant_c == RC_SEL_W'(i)) grant_data_c = slot_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          rep_d.data = RC_DATA_W'(grant_data_c);
          rep_d.ctrl = RC_CTRL_W'(grant_c);
          out_wr_d   = 1'b1;
          ch_sel_d   = grant_c;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept_c) begin
          out_wr_d = 1'b0;
          rr_ptr_d = rr_next(ch_sel_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rep_q    <= '0;
      out_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      ch_sel_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      out_wr_q <= out_wr_d;
      busy_q   <= (state_d != ST_IDLE);
      ch_sel_q <= ch_sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= '0;
      interval_q <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      pre_q      <= '0;
      for (int unsigned i = 0; i < RC_CHANNELS; i++) begin
        slot_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      enable_q   <= enable_d;
      interval_q <= interval_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      pre_q      <= pre_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
    end
  end

  assign host.out_data = rep_q.data;
  assign host.out_ctrl = rep_q.ctrl;
  assign host.out_wr   = out_wr_q;
  assign pending       = pending_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rc_report_scheduler.sv
// Scoreboard bench for rc_report_scheduler: expected reports queued at stimulus, checked at host accept.
module tb_rc_report_scheduler;
  import rc_pkg::*;

  localparam int unsigned RDIV = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [23:0]  cfg_data = '0;
  logic         cfg_wr = 1'b0;
  logic [6:0]   ch_stb = '0;
  logic [118:0] ch_data = '0;
  logic [6:0]   pending;
  logic [6:0]   overrun;
  logic         busy;
  logic         rdy = 1'b0;

  rc_report_scheduler_if host_if ();
  assign host_if.out_wr_rdy = rdy;

  rc_report_scheduler #(.RATE_DIV(RDIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_data (cfg_data),
    .cfg_wr   (cfg_wr),
    .ch_stb   (ch_stb),
    .ch_data  (ch_data),
    .host     (host_if),
    .pending  (pending),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int acc_cyc [7];
  logic [27:0] exp_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Host side monitor: every accepted report is popped from the scoreboard and compared.
  always @(negedge clk) begin : mon
    logic [27:0] got;
    logic [27:0] want;
    if (host_if.out_wr === 1'b1 && rdy === 1'b1) begin
      got = {host_if.out_ctrl, host_if.out_data};
      acc_cyc[host_if.out_ctrl[2:0]] = cyc_cnt;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL report_unexpected: got ctrl=%h data=%h, required no report", got[27:24], got[23:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL report_payload: got ctrl=%h data=%h, required ctrl=%h data=%h",
                   got[27:24], got[23:0], want[27:24], want[23:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_exp(input int ch, input logic [16:0] d);
    exp_q.push_back({4'(ch), 24'(d)});
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic cfg(input logic [6:0] en, input logic [7:0] ivl, input logic clr);
    cfg_data = {7'b0, clr, ivl, 1'b0, en};
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  // Channel i in mask receives d + i.
  task automatic strobe(input logic [6:0] mask, input logic [16:0] d);
    ch_stb = mask;
    for (int i = 0; i < 7; i++) if (mask[i]) ch_data[17*i +: 17] = d + 17'(i);
    step();
    ch_stb = '0;
  endtask

  // Returns just after a clock edge with out_wr high (host holding rdy low).
  task automatic wait_wr(input string nm);
    int n = 0;
    @(negedge clk);
    while (host_if.out_wr !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (host_if.out_wr !== 1'b1) begin
      bad++;
      $display("FAIL %s: out_wr=%b after %0d cycles, required 1", nm, host_if.out_wr, n);
    end
    step();
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || host_if.out_wr === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d reports outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({host_if.out_wr, host_if.out_data, host_if.out_ctrl, pending, overrun, busy} !== '0) begin
      bad++;
      $display("FAIL reset_state: wr=%b data=%h ctrl=%h pend=%b ovr=%b busy=%b, required all 0",
               host_if.out_wr, host_if.out_data, host_if.out_ctrl, pending, overrun, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    cfg(7'h7F, 8'd0, 1'b1);
    strobe(7'h08, 17'h00AB9);
    @(negedge clk);
    total++;
    if (pending[3] !== 1'b1 || host_if.out_wr !== 1'b0) begin
      bad++;
      $display("FAIL single_t1: pend3=%b wr=%b, required 1 0", pending[3], host_if.out_wr);
    end
    step();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({host_if.out_wr, host_if.out_ctrl, host_if.out_data, busy} !== {1'b1, 4'h3, 24'h000ABC, 1'b1}) begin
        bad++;
        $display("FAIL single_hold: wr=%b ctrl=%h data=%h busy=%b, required 1 3 000abc 1",
                 host_if.out_wr, host_if.out_ctrl, host_if.out_data, busy);
      end
      @(negedge clk);
    end
    step();
    put_exp(3, 17'h00ABC);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    @(negedge clk);
    total++;
    if (host_if.out_wr !== 1'b0 || pending[3] !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: wr=%b pend3=%b busy=%b, required 0 0 0", host_if.out_wr, pending[3], busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cfg(7'h7F, 8'd0, 1'b0);
    rdy = 1'b1;
    put_exp(0, 17'h01000);
    put_exp(2, 17'h01002);
    put_exp(5, 17'h01005);
    strobe(7'h25, 17'h01000);
    wait_drain("rr_first");
    total++;
    if (acc_cyc[2] - acc_cyc[0] != 2 || acc_cyc[5] - acc_cyc[2] != 2) begin
      bad++;
      $display("FAIL rr_spacing: gaps %0d %0d, required 2 2", acc_cyc[2] - acc_cyc[0], acc_cyc[5] - acc_cyc[2]);
    end
    put_exp(0, 17'h02000);
    put_exp(5, 17'h02005);
    strobe(7'h21, 17'h02000);
    wait_drain("rr_wrap");
    rdy = 1'b0;
  endtask

  task automatic test_overrun();
    put_exp(0, 17'h00F00);
    strobe(7'h01, 17'h00F00);
    strobe(7'h02, 17'h00110);
    strobe(7'h02, 17'h00221);
    @(negedge clk);
    total++;
    if (overrun[1] !== 1'b1 || pending[1] !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: ovr1=%b pend1=%b, required 1 1", overrun[1], pending[1]);
    end
    put_exp(1, 17'h00222);
    step();
    rdy = 1'b1;
    wait_drain("overrun_drain");
    rdy = 1'b0;
    cfg(7'h7F, 8'd0, 1'b1);
    @(negedge clk);
    total++;
    if (overrun[1] !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: ovr1=%b, required 0", overrun[1]);
    end
  endtask

  task automatic test_rate_limit();
    int t1;
    int gap;
    cfg(7'h7F, 8'd3, 1'b1);
    rdy = 1'b1;
    put_exp(2, 17'h02222);
    strobe(7'h04, 17'h02220);
    wait_drain("rate_first");
    t1 = acc_cyc[2];
    put_exp(4, 17'h03004);
    put_exp(2, 17'h03002);
    strobe(7'h14, 17'h03000);
    wait_drain("rate_second");
    gap = acc_cyc[2] - t1;
    total++;
    if (gap < 11 || gap > 14) begin
      bad++;
      $display("FAIL rate_gap: ch2 spacing %0d cycles, required 11..14", gap);
    end
    total++;
    if (acc_cyc[4] >= acc_cyc[2]) begin
      bad++;
      $display("FAIL rate_other: ch4 at %0d ch2 at %0d, required ch4 first", acc_cyc[4], acc_cyc[2]);
    end
    rdy = 1'b0;
    cfg(7'h7F, 8'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    put_exp(6, 17'h0A0A6);
    strobe(7'h40, 17'h0A0A0);
    wait_wr("b2b_grant");
    put_exp(6, 17'h15556);
    rdy = 1'b1;
    ch_stb = 7'h40;
    ch_data[17*6 +: 17] = 17'h15556;
    step();
    ch_stb = '0;
    rdy = 1'b0;
    @(negedge clk);
    total++;
    if (pending[6] !== 1'b1 || overrun[6] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flags: pend6=%b ovr6=%b, required 1 0", pending[6], overrun[6]);
    end
    step();
    rdy = 1'b1;
    wait_drain("b2b_drain");
    rdy = 1'b0;
  endtask

  task automatic test_disable_and_reset();
    put_exp(3, 17'h0C0D3);
    strobe(7'h08, 17'h0C0D0);
    wait_wr("dis_grant");
    cfg(7'h77, 8'd0, 1'b0);
    @(negedge clk);
    total++;
    if ({host_if.out_wr, host_if.out_ctrl, host_if.out_data, pending[3]} !== {1'b1, 4'h3, 24'h00C0D3, 1'b0}) begin
      bad++;
      $display("FAIL dis_hold: wr=%b ctrl=%h data=%h pend3=%b, required 1 3 00c0d3 0",
               host_if.out_wr, host_if.out_ctrl, host_if.out_data, pending[3]);
    end
    step();
    rdy = 1'b1;
    wait_drain("dis_drain");
    rdy = 1'b0;
    strobe(7'h08, 17'h01234);
    repeat (5) @(negedge clk);
    total++;
    if (pending[3] !== 1'b0 || host_if.out_wr !== 1'b0) begin
      bad++;
      $display("FAIL dis_ignore: pend3=%b wr=%b, required 0 0", pending[3], host_if.out_wr);
    end
    step();
    cfg(7'h7F, 8'd0, 1'b0);
    strobe(7'h02, 17'h0BEEF);
    wait_wr("rst_grant");
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({host_if.out_wr, host_if.out_data, host_if.out_ctrl, pending, overrun, busy} !== '0) begin
      bad++;
      $display("FAIL rst_midsend: wr=%b data=%h ctrl=%h pend=%b ovr=%b busy=%b, required all 0",
               host_if.out_wr, host_if.out_data, host_if.out_ctrl, pending, overrun, busy);
    end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_rate_limit();
    test_back_to_back();
    test_disable_and_reset();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_end: %0d left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
